// File: rtl/rf_pkg.sv
// Shared types for the refresh-interval feature sampler and its divider.
package rf_pkg;
  localparam logic [7:0] T_REFI_SAFE = 8'd32;

  // Codes match the walker's feature select inputs.
  typedef enum logic [2:0] {
    REQ  = 3'd1,
    LOAD = 3'd2,
    MISS = 3'd3,
    RISK = 3'd4,
    LOC  = 3'd5,
    CONF = 3'd6
  } feat_e;

  typedef enum logic [1:0] {COUNT, DIV, ISSUE, RELEASE} state_e;

  // Order in which the shared divider visits the ratio features.
  function automatic feat_e next_div(input feat_e f);
    case (f)
      LOAD:    return MISS;
      MISS:    return LOC;
      default: return CONF;
    endcase
  endfunction
endpackage

// File: rtl/rf_frac_div.sv
// Restoring divider: q = min(255, num*256/den), 0 when den==0.
// done pulses 10 cycles after an accepted go; go while busy is ignored.
module rf_frac_div
  import rf_pkg::*;
#(
  parameter int CNT_W = 18
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_go,
  input  logic [CNT_W-1:0] i_num,
  input  logic [CNT_W-1:0] i_den,
  output logic [7:0]       o_q,
  output logic             o_done
);
  logic [CNT_W:0]   r_rem;
  logic [CNT_W-1:0] r_den;
  logic [8:0]       r_quo;
  logic [3:0]       r_cnt;
  logic             r_busy;
  logic             w_ge;
  logic [CNT_W:0]   w_rem_nxt;

  assign w_ge      = r_rem >= {1'b0, r_den};
  assign w_rem_nxt = w_ge ? (r_rem - {1'b0, r_den}) : r_rem;

  // First iteration yields quotient bit 8 (num >= den), which alone forces saturation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      o_q    <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (!r_busy) begin
        if (i_go) begin
          r_rem  <= {1'b0, i_num};
          r_den  <= i_den;
          r_quo  <= '0;
          r_cnt  <= 4'd10;
          r_busy <= 1'b1;
        end
      end else if (r_cnt > 4'd1) begin
        r_quo <= {r_quo[7:0], w_ge};
        r_rem <= {w_rem_nxt[CNT_W-1:0], 1'b0};
        r_cnt <= r_cnt - 4'd1;
      end else begin
        o_q    <= (r_den == '0) ? 8'd0 : (r_quo[8] ? 8'hFF : r_quo[7:0]);
        o_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/rf_feature_sampler.sv
// Windowed event counters -> six 8-bit features -> walker handshake -> t_REFI republish.
// Conversion ~44 cycles after window end; windows closing while busy are dropped and flag overrun.
module rf_feature_sampler
  import rf_pkg::*;
#(
  parameter int WIN_LOG2 = 16,
  parameter int CNT_W    = WIN_LOG2 + 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_ev_req,
  input  logic       i_ev_llc_access,
  input  logic       i_ev_llc_miss,
  input  logic       i_ev_rb_hit,
  input  logic       i_ev_rb_miss,
  input  logic       i_ev_rb_conflict,
  input  logic       i_q_high,
  output logic [7:0] o_req_per_cycle,
  output logic [7:0] o_conflict_load,
  output logic [7:0] o_llc_miss,
  output logic [7:0] o_traffic_risk,
  output logic [7:0] o_rb_locality,
  output logic [7:0] o_rb_conflict,
  output logic       o_walker_start,
  input  logic       i_walker_done,
  input  logic [7:0] i_walker_t_refi,
  output logic [7:0] o_t_refi_out,
  output logic       o_t_refi_valid,
  output logic       o_busy,
  output logic       o_overrun
);
  localparam int I_REQ = 0, I_ACC = 1, I_MISS = 2, I_HIT = 3, I_RBM = 4, I_CONF = 5, I_QH = 6;

  state_e                  r_state;
  feat_e                   r_sel;
  logic                    r_go;
  logic [WIN_LOG2-1:0]     r_win;
  logic [6:0][CNT_W-1:0]   r_cnt;
  logic [5:0][CNT_W-1:0]   r_snap;
  logic [6:0][CNT_W-1:0]   w_cnt_inc;
  logic [6:0]              w_ev;
  logic                    w_win_end;
  logic [CNT_W-1:0]        w_rb;
  logic [CNT_W-1:0]        w_num;
  logic [CNT_W-1:0]        w_den;
  logic [7:0]              w_q;
  logic                    w_div_done;

  function automatic logic [7:0] sat8(input logic [CNT_W-1:0] v);
    return (v > CNT_W'(255)) ? 8'hFF : v[7:0];
  endfunction

  assign w_ev = {i_q_high, i_ev_rb_conflict, i_ev_rb_miss, i_ev_rb_hit,
                 i_ev_llc_miss, i_ev_llc_access, i_ev_req};
  assign w_win_end = i_enable && (&r_win);
  // Each term is bounded by the window length, so the sum fits CNT_W.
  assign w_rb   = r_snap[I_HIT] + r_snap[I_RBM] + r_snap[I_CONF];
  assign o_busy = (r_state != COUNT);

  always_comb begin
    w_cnt_inc = '0;
    for (int k = 0; k < 7; k++)
      w_cnt_inc[k] = (&r_cnt[k]) ? r_cnt[k] : r_cnt[k] + CNT_W'(w_ev[k]);
  end

  always_comb begin
    w_num = '0;
    w_den = '0;
    case (r_sel)
      LOAD:    begin w_num = r_snap[I_CONF]; w_den = r_snap[I_REQ]; end
      MISS:    begin w_num = r_snap[I_MISS]; w_den = r_snap[I_ACC]; end
      LOC:     begin w_num = r_snap[I_HIT];  w_den = w_rb;          end
      default: begin w_num = r_snap[I_CONF]; w_den = w_rb;          end
    endcase
  end

  rf_frac_div #(.CNT_W(CNT_W)) u_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_go   (r_go),
    .i_num  (w_num),
    .i_den  (w_den),
    .o_q    (w_q),
    .o_done (w_div_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= COUNT;
      r_sel           <= LOAD;
      r_go            <= 1'b0;
      r_win           <= '0;
      r_cnt           <= '0;
      r_snap          <= '0;
      o_req_per_cycle <= '0;
      o_conflict_load <= '0;
      o_llc_miss      <= '0;
      o_traffic_risk  <= '0;
      o_rb_locality   <= '0;
      o_rb_conflict   <= '0;
      o_walker_start  <= 1'b0;
      o_t_refi_out    <= T_REFI_SAFE;
      o_t_refi_valid  <= 1'b0;
      o_overrun       <= 1'b0;
    end else begin
      o_t_refi_valid <= 1'b0;
      r_go           <= 1'b0;
      if (i_enable) begin
        r_win <= r_win + WIN_LOG2'(1);
        r_cnt <= w_win_end ? '0 : w_cnt_inc;
      end
      if (w_win_end) begin
        if (r_state == COUNT) begin
          r_snap          <= w_cnt_inc[5:0];
          o_req_per_cycle <= sat8(w_cnt_inc[I_REQ] >> (WIN_LOG2 - 8));
          o_traffic_risk  <= sat8(w_cnt_inc[I_QH] >> (WIN_LOG2 - 8));
          r_sel           <= LOAD;
          r_go            <= 1'b1;
          r_state         <= DIV;
        end else begin
          o_overrun <= 1'b1;
        end
      end
      case (r_state)
        DIV: if (w_div_done) begin
          case (r_sel)
            LOAD:    o_conflict_load <= w_q;
            MISS:    o_llc_miss      <= w_q;
            LOC:     o_rb_locality   <= w_q;
            default: o_rb_conflict   <= w_q;
          endcase
          if (r_sel == CONF) begin
            o_walker_start <= 1'b1;
            r_state        <= ISSUE;
          end else begin
            r_sel <= next_div(r_sel);
            r_go  <= 1'b1;
          end
        end
        ISSUE: if (i_walker_done) begin
          o_t_refi_out   <= i_walker_t_refi;
          o_t_refi_valid <= 1'b1;
          o_walker_start <= 1'b0;
          r_state        <= RELEASE;
        end
        RELEASE: if (!i_walker_done) r_state <= COUNT;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_feature_sampler.sv
// Directed bench for rf_feature_sampler with a 256-cycle window.
module tb_rf_feature_sampler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enable, ev_req, ev_llc_access, ev_llc_miss;
  logic       ev_rb_hit, ev_rb_miss, ev_rb_conflict, q_high;
  logic       walker_done;
  logic [7:0] walker_t_refi;
  logic [7:0] req_per_cycle, conflict_load, llc_miss, traffic_risk, rb_locality, rb_conflict;
  logic       walker_start, t_refi_valid, busy, overrun;
  logic [7:0] t_refi_out;
  logic [47:0] feats;

  int checks = 0;
  int errors = 0;

  assign feats = {req_per_cycle, conflict_load, llc_miss, traffic_risk, rb_locality, rb_conflict};

  rf_feature_sampler #(.WIN_LOG2(8), .CNT_W(10)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_enable         (enable),
    .i_ev_req         (ev_req),
    .i_ev_llc_access  (ev_llc_access),
    .i_ev_llc_miss    (ev_llc_miss),
    .i_ev_rb_hit      (ev_rb_hit),
    .i_ev_rb_miss     (ev_rb_miss),
    .i_ev_rb_conflict (ev_rb_conflict),
    .i_q_high         (q_high),
    .o_req_per_cycle  (req_per_cycle),
    .o_conflict_load  (conflict_load),
    .o_llc_miss       (llc_miss),
    .o_traffic_risk   (traffic_risk),
    .o_rb_locality    (rb_locality),
    .o_rb_conflict    (rb_conflict),
    .o_walker_start   (walker_start),
    .i_walker_done    (walker_done),
    .i_walker_t_refi  (walker_t_refi),
    .o_t_refi_out     (t_refi_out),
    .o_t_refi_valid   (t_refi_valid),
    .o_busy           (busy),
    .o_overrun        (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full enabled window; strobe k is active for cycles i < n_k.
  task automatic run_window(input int n_req, input int n_acc, input int n_miss, input int n_hit,
                            input int n_rbm, input int n_conf, input int n_qh, input bit last_req);
    for (int i = 0; i < 256; i++) begin
      enable         = 1'b1;
      ev_req         = (i < n_req) || (last_req && i == 255);
      ev_llc_access  = (i < n_acc);
      ev_llc_miss    = (i < n_miss);
      ev_rb_hit      = (i < n_hit);
      ev_rb_miss     = (i < n_rbm);
      ev_rb_conflict = (i < n_conf);
      q_high         = (i < n_qh);
      tick();
    end
    enable = 1'b0;
    {ev_req, ev_llc_access, ev_llc_miss, ev_rb_hit, ev_rb_miss, ev_rb_conflict, q_high} = '0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (walker_start) ok = 1'b1;
    end
  endtask

  task automatic complete_walker(input logic [7:0] t);
    walker_t_refi = t;
    walker_done   = 1'b1;
    tick();
    tick();
    walker_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (feats !== 48'h0) begin errors++; $display("FAIL reset_feats got %h want 0", feats); end
    checks++; if (t_refi_out !== 8'd32) begin errors++; $display("FAIL reset_t_refi got %0d want 32", t_refi_out); end
    checks++; if ({walker_start, t_refi_valid, busy, overrun} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {walker_start, t_refi_valid, busy, overrun});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    run_window(64, 16, 4, 48, 8, 8, 32, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_start(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_start_timeout got 0 want 1"); end
    checks++; if (feats !== 48'h4020_4020_C020) begin
      errors++; $display("FAIL basic_feats got %h want 40204020c020", feats);
    end
    walker_t_refi = 8'd40;
    walker_done   = 1'b1;
    tick();
    checks++; if (t_refi_out !== 8'd40 || t_refi_valid !== 1'b1) begin
      errors++; $display("FAIL basic_accept got %0d/%b want 40/1", t_refi_out, t_refi_valid);
    end
    checks++; if (walker_start !== 1'b0) begin errors++; $display("FAIL basic_start_drop got %b want 0", walker_start); end
    tick();
    checks++; if (t_refi_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_release got valid=%b busy=%b want 0/1", t_refi_valid, busy);
    end
    walker_done = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", busy); end
  endtask

  task automatic test_idle();
    bit ok;
    run_window(0, 0, 0, 0, 0, 0, 0, 1'b0);
    wait_start(ok);
    checks++; if (!ok || feats !== 48'h0) begin
      errors++; $display("FAIL idle_feats got %h start=%b want 0 start=1", feats, ok);
    end
    walker_t_refi = 8'd64;
    walker_done   = 1'b1;
    tick();
    checks++; if (t_refi_out !== 8'd64 || t_refi_valid !== 1'b1) begin
      errors++; $display("FAIL idle_accept got %0d/%b want 64/1", t_refi_out, t_refi_valid);
    end
    tick();
    checks++; if (t_refi_valid !== 1'b0) begin errors++; $display("FAIL idle_pulse got %b want 0", t_refi_valid); end
    walker_done = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    bit ok;
    run_window(256, 10, 10, 0, 0, 0, 0, 1'b0);
    wait_start(ok);
    checks++; if (!ok || feats !== 48'hFF00_FF00_0000) begin
      errors++; $display("FAIL sat_feats got %h start=%b want ff00ff000000 start=1", feats, ok);
    end
    complete_walker(8'd50);
  endtask

  task automatic test_overrun();
    bit ok;
    bit restarted;
    run_window(128, 8, 2, 10, 20, 30, 100, 1'b0);
    wait_start(ok);
    checks++; if (!ok || feats !== 48'h803C_4064_2A80) begin
      errors++; $display("FAIL ovr_feats got %h start=%b want 803c40642a80 start=1", feats, ok);
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre got %b want 0", overrun); end
    run_window(200, 0, 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 44; i++) tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
    checks++; if (feats !== 48'h803C_4064_2A80 || walker_start !== 1'b1) begin
      errors++; $display("FAIL ovr_hold got %h start=%b want 803c40642a80 start=1", feats, walker_start);
    end
    walker_t_refi = 8'd48;
    walker_done   = 1'b1;
    tick();
    checks++; if (t_refi_out !== 8'd48 || walker_start !== 1'b0) begin
      errors++; $display("FAIL ovr_accept got %0d start=%b want 48 start=0", t_refi_out, walker_start);
    end
    restarted = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (walker_start) restarted = 1'b1;
    end
    checks++; if (restarted !== 1'b0) begin errors++; $display("FAIL ovr_no_restart got 1 want 0"); end
    walker_done = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_release got %b want 0", busy); end
  endtask

  task automatic test_window_edge();
    bit ok;
    run_window(0, 0, 0, 0, 0, 0, 0, 1'b1);
    wait_start(ok);
    checks++; if (!ok || feats !== 48'h0100_0000_0000) begin
      errors++; $display("FAIL edge_last got %h start=%b want 010000000000 start=1", feats, ok);
    end
    complete_walker(8'd60);
    run_window(0, 0, 0, 0, 0, 0, 0, 1'b0);
    wait_start(ok);
    checks++; if (!ok || feats !== 48'h0) begin
      errors++; $display("FAIL edge_next got %h start=%b want 0 start=1", feats, ok);
    end
    complete_walker(8'd60);
  endtask

  task automatic test_reset_mid_div();
    bit started;
    run_window(64, 16, 4, 48, 8, 8, 32, 1'b0);
    for (int i = 0; i < 25; i++) tick();
    checks++; if (busy !== 1'b1 || req_per_cycle !== 8'd64) begin
      errors++; $display("FAIL rstdiv_pre got busy=%b req=%0d want 1/64", busy, req_per_cycle);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (feats !== 48'h0 || t_refi_out !== 8'd32) begin
      errors++; $display("FAIL rstdiv_vals got %h/%0d want 0/32", feats, t_refi_out);
    end
    checks++; if (busy !== 1'b0 || walker_start !== 1'b0) begin
      errors++; $display("FAIL rstdiv_flags got busy=%b start=%b want 0/0", busy, walker_start);
    end
    started = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (walker_start) started = 1'b1;
    end
    checks++; if (started !== 1'b0) begin errors++; $display("FAIL rstdiv_no_start got 1 want 0"); end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    {ev_req, ev_llc_access, ev_llc_miss, ev_rb_hit, ev_rb_miss, ev_rb_conflict, q_high} = '0;
    walker_done   = 1'b0;
    walker_t_refi = 8'd0;
    test_reset();
    test_basic();
    test_idle();
    test_saturation();
    test_overrun();
    test_window_edge();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_feature_sampler.md
Name: rf_feature_sampler

Overview:
- Upstream stage of the refresh-interval ROM tree walker.
- Counts memory-system events over a fixed power-of-two window, snapshots the counts at window end, and converts them into the six 8-bit features (x/256 scaling) using one shared sequential fractional divider.
- Presents the features to the walker, runs its start/done handshake, and republishes the resulting t_REFI to the refresh scheduler.

Parameters:
- WIN_LOG2, 16, window length = 2^WIN_LOG2 cycles; legal range 8..24.
- CNT_W, WIN_LOG2+2, width of every event counter and divider operand.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  low: window counter and event counters freeze; in-flight conversion/handshake continues.
- ev_req  in  1  memory request issued this cycle.
- ev_llc_access  in  1  LLC lookup this cycle.
- ev_llc_miss  in  1  LLC miss this cycle.
- ev_rb_hit  in  1  row-buffer hit.
- ev_rb_miss  in  1  row-buffer miss (closed row).
- ev_rb_conflict  in  1  row-buffer conflict.
- q_high  in  1  request queue above high watermark this cycle.
- req_per_cycle, conflict_load, llc_miss, traffic_risk, rb_locality, rb_conflict  out  8 each  feature registers to the walker.
- walker_start  out  1  walker start level.
- walker_done  in  1  walker done level.
- walker_t_refi  in  8  walker result.
- t_refi_out  out  8  latest accepted t_REFI.
- t_refi_valid  out  1  one-cycle pulse when t_refi_out updates.
- busy  out  1  high in any state other than COUNT.
- overrun  out  1  sticky: a window closed while busy.

Behaviour:
- Reset values: all features 0, walker_start 0, t_refi_out 8'd32 (most conservative interval), t_refi_valid 0, busy 0, overrun 0. State is COUNT, window counter 0, all counters 0.
- Counting:
  - Each enabled cycle, every counter adds its strobe, saturating at 2^CNT_W-1.
  - Window counter increments each enabled cycle. When it reaches 2^WIN_LOG2-1 (window end), the counters are snapshotted, including that cycle's strobes, and the live counters clear to 0.
- Snapshot acceptance:
  - In COUNT, the snapshot is accepted and the block enters DIV.
  - In any other state, the snapshot is discarded, overrun is set, and counting continues.
- Feature arithmetic (snapshots S_x; RB = S_rb_hit + S_rb_miss + S_rb_conflict):
  - req_per_cycle = min(255, S_req >> (WIN_LOG2-8)).
  - traffic_risk = min(255, S_q_high >> (WIN_LOG2-8)).
  - Shift features load on DIV entry.
  - Divided features use frac(n,d) = min(255, floor(n*256/d)), and frac(n,0) = 0:
    - conflict_load = frac(S_rb_conflict, S_req)
    - llc_miss = frac(S_llc_miss, S_llc_access)
    - rb_locality = frac(S_rb_hit, RB)
    - rb_conflict = frac(S_rb_conflict, RB)
- FSM:
  - COUNT: idle; waits for an accepted snapshot.
  - DIV: issues four divides in the order listed above. Each result writes its feature register on divider done. After the fourth, go to ISSUE.
  - ISSUE: walker_start=1 (all features already stable). On walker_done=1: latch t_refi_out <= walker_t_refi, pulse t_refi_valid, drop walker_start next cycle, go to RELEASE.
  - RELEASE: walker_start=0; wait for walker_done=0, then go to COUNT. No new start may be issued while walker_done is high.
- Features hold their values outside DIV; they are never partially updated during ISSUE or RELEASE.
- rst in any state (including mid-divide or mid-handshake) restores the reset values on the next edge and drops walker_start.
- Worst-case conversion is about 44 cycles, well under the minimum 256-cycle window, so overrun indicates only a stalled walker.

Decomposition:
- Package rf_pkg holds:
  - feature index enum (REQ=1, LOAD=2, MISS=3, RISK=4, LOC=5, CONF=6), matching the walker's select codes;
  - FSM state enum {COUNT, DIV, ISSUE, RELEASE};
  - T_REFI_SAFE = 8'd32.
- Sub-module rf_frac_div (restoring divider):
  - Ports: clk, rst, go, num[CNT_W-1:0], den[CNT_W-1:0], q[7:0], done.
  - Computes a 9-bit quotient of num*256/den over 9 iterations, then saturates to 8 bits.
  - done pulses exactly 10 cycles after go; den==0 returns 0.
  - go while busy is ignored.

Test Plan (WIN_LOG2=8, window 256 cycles):
- One window with 64 req, 16 llc_access of which 4 miss, 48 rb_hit / 8 rb_miss / 8 rb_conflict, 32 q_high cycles -> req_per_cycle=64, llc_miss=64, rb_locality=192, rb_conflict=32, conflict_load=32, traffic_risk=32; walker_start rises with all features stable.
- Idle window (no strobes) -> all features 0 (zero-denominator rule); walker returns 64 -> t_refi_out=64, one-cycle t_refi_valid.
- Saturation: ev_req every cycle (256) and llc_miss=llc_access=10 -> req_per_cycle=255, llc_miss=255.
- Walker holds done low for 300 cycles -> overrun=1 and features unchanged; then done=1 with t_refi 48 -> t_refi_out=48, start drops the next cycle, no restart until done falls.
- Strobe on the window-end cycle -> counted in the closing window; the next window's count starts at 0.
- rst asserted mid-DIV -> next cycle: features 0, t_refi_out=32, busy=0, no walker_start.
